// File: rtl/rv_pkg.sv
// Shared constants and dump FSM encoding for the RV32I integer register file.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int AW       = 5;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Serial register dump: walks x0..x(NREG-1) over a valid/ready beat stream,
// snapshotting each value through a private read tap on the array.
module regfile_dump_fsm
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int NREG = rv_pkg::NREG,
    parameter int AW   = rv_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump_start,
    input  logic            dump_ready,
    input  logic [XLEN-1:0] tap_data,
    output logic [AW-1:0]   tap_addr,
    output dump_state_t     state_o,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data
);

    dump_state_t     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] data_q, data_d;

    // The tap always looks one register ahead so the next beat's value is
    // captured at the same edge the current beat is accepted (pre-write value).
    assign tap_addr  = idx_q + AW'(1);
    assign state_o   = state_q;
    assign dump_idx  = idx_q;
    assign dump_data = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SEND;
                    idx_d   = '0;
                    data_d  = '0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (idx_q == AW'(NREG - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + AW'(1);
                        data_d = tap_data;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/regfile_2r1w.sv
// RV32I integer register file: two combinational read ports, one synchronous
// write port, optional write-to-read forwarding and a non-intrusive dump port.
module regfile_2r1w
    import rv_pkg::*;
#(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int NREG   = rv_pkg::NREG,
    parameter int AW     = rv_pkg::AW,
    parameter int BYPASS = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wd,
    input  logic            dump_start,
    output logic            dump_busy,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_en;
    logic [AW-1:0]   tap_addr;
    logic [XLEN-1:0] tap_data;
    dump_state_t     dump_state;

    assign wr_en = we && (rd_addr != AW'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_addr] <= wd;
        end
    end

    // wr_en already excludes x0, so forwarding can never make x0 non-zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1_addr != AW'(REG_ZERO)) begin
            rd1 = (BYPASS != 0 && wr_en && rd_addr == rs1_addr) ? wd : regs_q[rs1_addr];
        end
        if (rs2_addr != AW'(REG_ZERO)) begin
            rd2 = (BYPASS != 0 && wr_en && rd_addr == rs2_addr) ? wd : regs_q[rs2_addr];
        end
    end

    assign tap_data = regs_q[tap_addr];

    regfile_dump_fsm #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .tap_data   (tap_data),
        .tap_addr   (tap_addr),
        .state_o    (dump_state),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data)
    );

    assign dump_valid = (dump_state == SEND);
    assign dump_busy  = (dump_state == SEND);
    assign dump_done  = (dump_state == DONE);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: plain and bypassing instances share inputs;
// dump beats are checked against a queue filled from a reference register model.
module tb_regfile_2r1w;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   rs1_addr = '0;
    logic [AW-1:0]   rs2_addr = '0;
    logic            we = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic [XLEN-1:0] wd = '0;
    logic            dump_start = 1'b0;
    logic            dump_ready = 1'b0;

    logic [XLEN-1:0] rd1_p, rd2_p, rd1_b, rd2_b;
    logic            busy_p, valid_p, done_p, busy_b, valid_b, done_b;
    logic [AW-1:0]   idx_p, idx_b;
    logic [XLEN-1:0] data_p, data_b;

    logic [XLEN-1:0] model [NREG];
    logic [XLEN-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(0)) u_plain (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1(rd1_p), .rd2(rd2_p), .we(we), .rd_addr(rd_addr), .wd(wd),
        .dump_start(dump_start), .dump_busy(busy_p), .dump_valid(valid_p),
        .dump_ready(dump_ready), .dump_idx(idx_p), .dump_data(data_p), .dump_done(done_p)
    );

    regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1(rd1_b), .rd2(rd2_b), .we(we), .rd_addr(rd_addr), .wd(wd),
        .dump_start(dump_start), .dump_busy(busy_b), .dump_valid(valid_b),
        .dump_ready(dump_ready), .dump_idx(idx_b), .dump_data(data_b), .dump_done(done_b)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int addr, input logic [XLEN-1:0] val);
        we = 1'b1;
        rd_addr = AW'(addr);
        wd = val;
        tick();
        we = 1'b0;
        if (addr != 0) model[addr] = val;
    endtask

    // Pulses dump_start, queues the model snapshot, then consumes beats.
    // stall_mode: hold ready low at beat 7 for 3 cycles, writing x7 and
    // re-pulsing dump_start inside the stall. rst_at >= 0: assert reset there.
    task automatic run_dump(input bit stall_mode, input int rst_at, output int beats);
        int cyc;
        int stall;
        logic [XLEN-1:0] e;
        beats = 0;
        cyc   = 0;
        stall = 0;
        exp_q.delete();
        for (int i = 0; i < NREG; i++) exp_q.push_back(model[i]);
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        while (beats < NREG && cyc < 200) begin
            cyc++;
            if (rst_at >= 0 && beats == rst_at) begin
                check("idx_before_rst", {27'd0, idx_p}, XLEN'(rst_at));
                rst = 1'b1;
                #1;
                exp_q.delete();
                for (int i = 0; i < NREG; i++) model[i] = '0;
                return;
            end
            if (stall_mode && beats == 7 && stall < 3) begin
                dump_ready = 1'b0;
                if (stall == 0) begin
                    we = 1'b1; rd_addr = AW'(7); wd = 32'h0000_CAFE;
                end
                if (stall == 1) dump_start = 1'b1;
                #1;
                check("stall_valid", {31'd0, valid_p}, 32'd1);
                check("stall_idx", {27'd0, idx_p}, 32'd7);
                check("stall_data", data_p, exp_q[0]);
                stall++;
                tick();
                if (we) model[7] = 32'h0000_CAFE;
                we = 1'b0;
                dump_start = 1'b0;
            end else begin
                dump_ready = 1'b1;
                #1;
                e = exp_q.pop_front();
                check("beat_valid", {31'd0, valid_p}, 32'd1);
                check("beat_busy", {31'd0, busy_p}, 32'd1);
                check("beat_idx", {27'd0, idx_p}, XLEN'(beats));
                check("beat_data", data_p, e);
                check("beat_data_byp", data_b, e);
                beats++;
                tick();
            end
        end
        dump_ready = 1'b0;
        check("beat_count", XLEN'(beats), XLEN'(NREG));
        check("done_pulse", {31'd0, done_p}, 32'd1);
        check("done_busy", {31'd0, busy_p}, 32'd0);
        check("done_valid", {31'd0, valid_p}, 32'd0);
        tick();
        check("done_cleared", {31'd0, done_p}, 32'd0);
        check("idle_valid", {31'd0, valid_p}, 32'd0);
    endtask

    initial begin
        int beats;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        // 1: reset state, then a basic write
        rs1_addr = AW'(5);
        rs2_addr = AW'(5);
        #1;
        check("rst_rd1", rd1_p, '0);
        check("rst_rd2", rd2_p, '0);
        check("rst_valid", {31'd0, valid_p}, 32'd0);
        check("rst_busy", {31'd0, busy_p}, 32'd0);
        check("rst_done", {31'd0, done_p}, 32'd0);
        check("rst_idx", {27'd0, idx_p}, 32'd0);
        check("rst_data", data_p, '0);
        tick();
        rst = 1'b0;
        tick();
        write_reg(5, 32'hDEAD_BEEF);
        check("wr5_rd1", rd1_p, 32'hDEAD_BEEF);
        check("wr5_rd2", rd2_p, 32'hDEAD_BEEF);
        check("wr5_rd1_byp", rd1_b, 32'hDEAD_BEEF);

        // 2: x0 writes are discarded, never bypassed
        rs1_addr = '0;
        we = 1'b1; rd_addr = '0; wd = 32'h1234_5678;
        #1;
        check("x0_comb", rd1_p, '0);
        check("x0_comb_byp", rd1_b, '0);
        tick();
        we = 1'b0;
        check("x0_after", rd1_p, '0);
        check("x0_after_byp", rd1_b, '0);

        // 3: bypass vs plain read across a write edge
        write_reg(3, 32'h11);
        rs1_addr = AW'(3);
        rs2_addr = AW'(3);
        we = 1'b1; rd_addr = AW'(3); wd = 32'h22;
        #1;
        check("nobyp_old", rd1_p, 32'h11);
        check("nobyp_old_rd2", rd2_p, 32'h11);
        check("byp_new", rd1_b, 32'h22);
        check("byp_new_rd2", rd2_b, 32'h22);
        tick();
        we = 1'b0;
        model[3] = 32'h22;
        check("nobyp_after", rd1_p, 32'h22);
        check("byp_after", rd1_b, 32'h22);

        // 4: full dump with ready held high
        for (int i = 1; i < NREG; i++) write_reg(i, XLEN'(i) * 32'h0101_0101);
        run_dump(1'b0, -1, beats);

        // 5: stall at beat 7 with a write to x7 and an ignored dump_start
        run_dump(1'b1, -1, beats);
        rs1_addr = AW'(7);
        #1;
        check("x7_after_stall", rd1_p, 32'h0000_CAFE);

        // 6: reset at beat 10 aborts the dump
        run_dump(1'b0, 10, beats);
        check("abort_valid", {31'd0, valid_p}, 32'd0);
        check("abort_busy", {31'd0, busy_p}, 32'd0);
        check("abort_done", {31'd0, done_p}, 32'd0);
        check("abort_idx", {27'd0, idx_p}, 32'd0);
        check("abort_data", data_p, '0);
        tick();
        rst = 1'b0;
        dump_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("no_done_after_abort", {31'd0, done_p}, 32'd0);
        end
        for (int i = 0; i < NREG; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(NREG - 1 - i);
            #1;
            check("cleared_rd1", rd1_p, '0);
            check("cleared_rd2", rd2_p, '0);
        end
        run_dump(1'b0, -1, beats);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
